// File: rtl/uart8_transmitter_pkg.sv
// Shared UART definitions used by the transmitter and, later, the receiver.
//   - uart_state_e : frame FSM state codes (IDLE/START/DATA/PARITY/STOP)
//   - Parity*      : PARITY_MODE codes (0=none 1=even 2=odd 3=mark 4=space)
//   - parity_bit() : parity value for one data byte under a given mode
package uart8_transmitter_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_state_e;

    localparam int unsigned ParityNone  = 0;
    localparam int unsigned ParityEven  = 1;
    localparam int unsigned ParityOdd   = 2;
    localparam int unsigned ParityMark  = 3;
    localparam int unsigned ParitySpace = 4;

    // Even parity makes the total count of ones (data + parity) even.
    function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
        logic p;
        case (mode)
            ParityEven: p = ^data;
            ParityOdd:  p = ~^data;
            ParityMark: p = 1'b1;
            default:    p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..OVERSAMPLE-1 and wraps, one wrap per serial bit.
// Ports:
//   clk     in   oversampling clock
//   rst     in   asynchronous, active-high reset (count -> 0)
//   clear   in   synchronous clear; holds the count at 0 while asserted
//   pre_end out  count == OVERSAMPLE-2 (lets registered outputs line up with bit_end)
//   bit_end out  count == OVERSAMPLE-1 (last cycle of the current bit)
module uart_bit_timer #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic pre_end,
    output logic bit_end
);

    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
    localparam logic [CntW-1:0] CntPre  = CntW'(OVERSAMPLE - 2);

    logic [CntW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        pre_end = (cnt == CntPre);
        bit_end = (cnt == CntLast);
    end

endmodule

// File: rtl/uart8_transmitter.sv
// 8-bit UART transmitter fed from a first-word-fall-through TX FIFO.
// Frame: start(0), 8 data bits LSB first, optional parity, 1 or 2 stop bits(1).
// Every bit lasts OVERSAMPLE clocks. Consecutive queued bytes are sent with no idle gap.
// Ports:
//   clk        in   OVERSAMPLE x baud clock
//   rst        in   asynchronous, active-high reset
//   en         in   transmit enable, consulted only at a pop decision
//   fifo_empty in   TX FIFO empty flag
//   fifo_data  in   [7:0] FIFO head, valid whenever !fifo_empty
//   fifo_rd    out  one-cycle registered pop strobe
//   out        out  registered serial line, idle high
//   busy       out  registered, high from pop to end of the last stop bit
//   done       out  registered one-cycle pulse in the last cycle of the last stop bit
//   txReady    out  combinational: en & ~fifo_empty & idle
module uart8_transmitter
    import uart8_transmitter_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned PARITY_MODE = ParityNone,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       out,
    output logic       busy,
    output logic       done,
    output logic       txReady
);

    localparam bit HasParity = (PARITY_MODE != 0);
    // Any STOP_BITS value other than 2 gives a single stop bit.
    localparam bit TwoStop   = (STOP_BITS == 2);

    uart_state_e state;
    logic [7:0]  shreg;
    logic        par;
    logic [2:0]  bit_idx;
    logic        stop_idx;
    logic        pre_end;
    logic        bit_end;
    logic        timer_clear;
    logic        last_stop;

    // Timer sits at 0 while idle so the start bit gets its full OVERSAMPLE cycles.
    assign timer_clear = (state == StIdle);
    assign last_stop   = TwoStop ? stop_idx : 1'b1;
    assign txReady     = en & ~fifo_empty & (state == StIdle);

    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .pre_end(pre_end),
        .bit_end(bit_end)
    );

    // Outputs are registered, so each assignment to out below is the level for the bit
    // that begins on this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            out      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            fifo_rd  <= 1'b0;
            shreg    <= '0;
            par      <= 1'b0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else begin
            fifo_rd <= 1'b0;
            done    <= 1'b0;
            case (state)
                StIdle: begin
                    out      <= 1'b1;
                    busy     <= 1'b0;
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    if (txReady) begin
                        fifo_rd <= 1'b1;
                        busy    <= 1'b1;
                        out     <= 1'b0;
                        shreg   <= fifo_data;
                        par     <= parity_bit(fifo_data, PARITY_MODE);
                        state   <= StStart;
                    end
                end

                StStart: begin
                    if (bit_end) begin
                        state   <= StData;
                        bit_idx <= '0;
                        out     <= shreg[0];
                    end
                end

                StData: begin
                    if (bit_end) begin
                        shreg <= {1'b0, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            if (HasParity) begin
                                state <= StParity;
                                out   <= par;
                            end else begin
                                state    <= StStop;
                                out      <= 1'b1;
                                stop_idx <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            out     <= shreg[1];
                        end
                    end
                end

                StParity: begin
                    if (bit_end) begin
                        state    <= StStop;
                        out      <= 1'b1;
                        stop_idx <= 1'b0;
                    end
                end

                StStop: begin
                    // Decide one cycle early so done and the next pop land in the final
                    // stop cycle itself; the popped byte is captured as that cycle ends.
                    if (last_stop && pre_end) begin
                        done <= 1'b1;
                        if (en && !fifo_empty) begin
                            fifo_rd <= 1'b1;
                        end
                    end
                    if (bit_end) begin
                        if (!last_stop) begin
                            stop_idx <= 1'b1;
                        end else if (fifo_rd) begin
                            shreg    <= fifo_data;
                            par      <= parity_bit(fifo_data, PARITY_MODE);
                            state    <= StStart;
                            out      <= 1'b0;
                            stop_idx <= 1'b0;
                        end else begin
                            state    <= StIdle;
                            out      <= 1'b1;
                            busy     <= 1'b0;
                            stop_idx <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= StIdle;
                    out   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart8_transmitter.sv
// Directed bench for uart8_transmitter. Four instances cover the parameter sets:
//   0: no parity, 1 stop   1: even parity   2: odd parity   3: no parity, 2 stop
// A queue models the FWFT FIFO shared by all instances; only one en bit is high at a time.
module tb_uart8_transmitter;

    logic       clk;
    logic       rst;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic [3:0] en;
    wire  [3:0] frd;
    wire  [3:0] txo;
    wire  [3:0] busy;
    wire  [3:0] done;
    wire  [3:0] rdy;

    int checks;
    int errors;
    int pops;
    int rd_empty;
    bit pend;

    logic [7:0] q[$];

    logic out_s  [0:399];
    logic done_s [0:399];
    logic busy_s [0:399];
    logic frd_s  [0:399];

    uart8_transmitter #(.OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)) u_n1 (
        .clk(clk), .rst(rst), .en(en[0]), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd(frd[0]), .out(txo[0]), .busy(busy[0]), .done(done[0]), .txReady(rdy[0])
    );
    uart8_transmitter #(.OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1)) u_e1 (
        .clk(clk), .rst(rst), .en(en[1]), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd(frd[1]), .out(txo[1]), .busy(busy[1]), .done(done[1]), .txReady(rdy[1])
    );
    uart8_transmitter #(.OVERSAMPLE(16), .PARITY_MODE(2), .STOP_BITS(1)) u_o1 (
        .clk(clk), .rst(rst), .en(en[2]), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd(frd[2]), .out(txo[2]), .busy(busy[2]), .done(done[2]), .txReady(rdy[2])
    );
    uart8_transmitter #(.OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(2)) u_n2 (
        .clk(clk), .rst(rst), .en(en[3]), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd(frd[3]), .out(txo[3]), .busy(busy[3]), .done(done[3]), .txReady(rdy[3])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO pops on the edge that ends a fifo_rd cycle.
    always begin
        @(negedge clk);
        pend = |frd;
        @(posedge clk);
        #1;
        if (pend && q.size() > 0) begin
            void'(q.pop_front());
            pops++;
            fifo_empty = (q.size() == 0);
            if (q.size() > 0) fifo_data = q[0];
        end
    end

    always @(negedge clk) begin
        if ((|frd) && fifo_empty) rd_empty++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before 2 ms");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        fifo_data  = q[0];
        fifo_empty = 1'b0;
    endtask

    task automatic wait_low(input int idx, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (txo[idx] == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Samples start at the current negedge (first low cycle), one per cycle.
    task automatic record(input int idx, input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            out_s[i]  = txo[idx];
            done_s[i] = done[idx];
            busy_s[i] = busy[idx];
            frd_s[i]  = frd[idx];
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (txo !== 4'b1111) begin
            errors++; $display("FAIL reset_out: got %b want 1111", txo);
        end
        checks++;
        if (busy !== 4'b0000) begin
            errors++; $display("FAIL reset_busy: got %b want 0000", busy);
        end
        checks++;
        if (done !== 4'b0000) begin
            errors++; $display("FAIL reset_done: got %b want 0000", done);
        end
        checks++;
        if (frd !== 4'b0000) begin
            errors++; $display("FAIL reset_fifo_rd: got %b want 0000", frd);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (txo !== 4'b1111 || rdy !== 4'b0000) begin
            errors++; $display("FAIL post_reset_idle: got out=%b rdy=%b want 1111/0000", txo, rdy);
        end
    endtask

    task automatic test_frame_8n1();
        logic [9:0] exp;
        int bad;
        int cnt;
        int p0;
        bit ok;
        p0 = pops;
        push(8'hA5);
        en[0] = 1'b1;
        wait_low(0, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL a5_start: got no start bit want one within 40 cycles");
        end
        record(0, 170);
        en = '0;
        exp = {1'b1, 8'hA5, 1'b0};  // line order 0,1,0,1,0,0,1,0,1,1
        for (int k = 0; k < 10; k++) begin
            bad = 0;
            for (int j = 0; j < 16; j++) if (out_s[16*k+j] !== exp[k]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL a5_bit%0d: got %0d wrong cycles want line %b for 16", k, bad, exp[k]);
            end
        end
        cnt = 0;
        for (int i = 0; i < 170; i++) if (done_s[i] === 1'b1) cnt++;
        checks++;
        if (done_s[159] !== 1'b1 || cnt != 1) begin
            errors++;
            $display("FAIL a5_done: got done@160=%b pulses=%0d want 1/1", done_s[159], cnt);
        end
        bad = 0;
        for (int i = 0; i < 160; i++) if (busy_s[i] !== 1'b1) bad++;
        checks++;
        if (bad != 0 || busy_s[160] !== 1'b0) begin
            errors++;
            $display("FAIL a5_busy: got %0d low in frame, after=%b want 0/0", bad, busy_s[160]);
        end
        bad = 0;
        for (int i = 160; i < 170; i++) if (out_s[i] !== 1'b1) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL a5_idle: got %0d low idle cycles want 0", bad);
        end
        checks++;
        if (pops - p0 != 1) begin
            errors++; $display("FAIL a5_pops: got %0d want 1", pops - p0);
        end
    endtask

    task automatic test_parity();
        logic [10:0] exp;
        logic        par_exp;
        int bad;
        bit ok;
        for (int m = 1; m <= 2; m++) begin
            // 0x07 has three ones: even parity -> 1, odd parity -> 0
            par_exp = (m == 1) ? 1'b1 : 1'b0;
            exp = {1'b1, par_exp, 8'h07, 1'b0};
            push(8'h07);
            en[m] = 1'b1;
            wait_low(m, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL par%0d_start: got no start bit want one", m);
            end
            record(m, 180);
            en = '0;
            for (int k = 0; k < 11; k++) begin
                bad = 0;
                for (int j = 0; j < 16; j++) if (out_s[16*k+j] !== exp[k]) bad++;
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL par%0d_bit%0d: got %0d wrong cycles want line %b",
                             m, k, bad, exp[k]);
                end
            end
            checks++;
            if (done_s[175] !== 1'b1 || done_s[174] !== 1'b0 || busy_s[176] !== 1'b0) begin
                errors++;
                $display("FAIL par%0d_len: got done@175=%b done@174=%b busy@176=%b want 1/0/0",
                         m, done_s[175], done_s[174], busy_s[176]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp;
        int bad;
        int cnt_d;
        int cnt_r;
        int p0;
        bit ok;
        p0 = pops;
        push(8'h55);
        push(8'hFF);
        en[0] = 1'b1;
        wait_low(0, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL b2b_start: got no start bit want one");
        end
        record(0, 330);
        en = '0;
        exp = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 20; k++) begin
            bad = 0;
            for (int j = 0; j < 16; j++) if (out_s[16*k+j] !== exp[k]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL b2b_bit%0d: got %0d wrong cycles want line %b", k, bad, exp[k]);
            end
        end
        checks++;
        if (frd_s[159] !== 1'b1 || done_s[159] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pop_on_done: got rd=%b done=%b want 1/1", frd_s[159], done_s[159]);
        end
        cnt_d = 0;
        cnt_r = 0;
        for (int i = 0; i < 330; i++) begin
            if (done_s[i] === 1'b1) cnt_d++;
            if (frd_s[i] === 1'b1) cnt_r++;
        end
        checks++;
        if (cnt_d != 2 || done_s[319] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: got pulses=%0d done@320=%b want 2/1", cnt_d, done_s[319]);
        end
        checks++;
        if (cnt_r != 2) begin
            errors++; $display("FAIL b2b_rd_count: got %0d want 2", cnt_r);
        end
        bad = 0;
        for (int i = 0; i < 320; i++) if (busy_s[i] !== 1'b1) bad++;
        checks++;
        if (bad != 0 || busy_s[320] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy: got %0d drops, after=%b want 0/0", bad, busy_s[320]);
        end
        checks++;
        if (pops - p0 != 2) begin
            errors++; $display("FAIL b2b_pops: got %0d want 2", pops - p0);
        end
    endtask

    task automatic test_enable();
        logic [9:0] exp;
        int bad;
        int cnt;
        int p0;
        bit ok;
        en = '0;
        p0 = pops;
        push(8'h3C);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (txo[0] !== 1'b1 || frd[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || pops != p0) begin
            errors++; $display("FAIL en_off: got %0d bad cycles %0d pops want 0/0", bad, pops - p0);
        end
        checks++;
        if (rdy[0] !== 1'b0) begin
            errors++; $display("FAIL en_off_ready: got %b want 0", rdy[0]);
        end
        en[0] = 1'b1;
        wait_low(0, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL en_start: got no start bit want one");
        end
        fork
            record(0, 170);
            begin
                repeat (50) @(negedge clk);
                en[0] = 1'b0;
                push(8'h99);
            end
        join
        exp = {1'b1, 8'h3C, 1'b0};
        for (int k = 0; k < 10; k++) begin
            bad = 0;
            for (int j = 0; j < 16; j++) if (out_s[16*k+j] !== exp[k]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL en_bit%0d: got %0d wrong cycles want line %b", k, bad, exp[k]);
            end
        end
        cnt = 0;
        for (int i = 0; i < 170; i++) if (frd_s[i] === 1'b1) cnt++;
        checks++;
        if (done_s[159] !== 1'b1 || busy_s[160] !== 1'b0 || out_s[169] !== 1'b1) begin
            errors++;
            $display("FAIL en_drop_done: got done=%b busy=%b out=%b want 1/0/1",
                     done_s[159], busy_s[160], out_s[169]);
        end
        checks++;
        if (cnt != 1 || pops - p0 != 1 || q.size() != 1) begin
            errors++;
            $display("FAIL en_drop_pops: got rd=%0d pops=%0d left=%0d want 1/1/1",
                     cnt, pops - p0, q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] exp;
        int bad;
        bit ok;
        en[0] = 1'b1;  // sends the 0x99 left queued by the previous test
        wait_low(0, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rst_mid_start: got no start bit want one");
        end
        repeat (39) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (txo[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0 || frd[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: got out=%b busy=%b done=%b rd=%b want 1/0/0/0",
                     txo[0], busy[0], done[0], frd[0]);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (txo[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle: got out=%b busy=%b want 1/0", txo[0], busy[0]);
        end
        push(8'h5A);
        wait_low(0, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rst_after_start: got no start bit want one");
        end
        record(0, 170);
        en = '0;
        exp = {1'b1, 8'h5A, 1'b0};
        for (int k = 0; k < 10; k++) begin
            bad = 0;
            for (int j = 0; j < 16; j++) if (out_s[16*k+j] !== exp[k]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rst_after_bit%0d: got %0d wrong cycles want line %b",
                         k, bad, exp[k]);
            end
        end
        checks++;
        if (done_s[159] !== 1'b1 || done_s[158] !== 1'b0) begin
            errors++;
            $display("FAIL rst_after_done: got %b%b want 01", done_s[158], done_s[159]);
        end
    endtask

    task automatic test_two_stop();
        logic [7:0] rx;
        logic       rx_err;
        int bad;
        int cnt;
        bit ok;
        en[3] = 1'b1;
        push(8'h00);
        wait_low(3, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL s2_start: got no start bit want one");
        end
        record(3, 180);
        en = '0;
        bad = 0;
        for (int i = 0; i < 144; i++) if (out_s[i] !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL s2_low: got %0d high cycles want 0", bad);
        end
        bad = 0;
        for (int i = 144; i < 176; i++) if (out_s[i] !== 1'b1) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL s2_stop32: got %0d low stop cycles want 0", bad);
        end
        cnt = 0;
        for (int i = 0; i < 180; i++) if (done_s[i] === 1'b1) cnt++;
        checks++;
        if (done_s[175] !== 1'b1 || cnt != 1 || busy_s[176] !== 1'b0) begin
            errors++;
            $display("FAIL s2_done: got done@176=%b pulses=%0d busy=%b want 1/1/0",
                     done_s[175], cnt, busy_s[176]);
        end
        // Loopback receiver: sample each bit at mid-period.
        for (int k = 0; k < 8; k++) rx[k] = out_s[16*(k+1)+8];
        rx_err = (out_s[8] !== 1'b0) || (out_s[152] !== 1'b1) || (out_s[168] !== 1'b1);
        checks++;
        if (rx !== 8'h00) begin
            errors++; $display("FAIL s2_rx_byte: got %h want 00", rx);
        end
        checks++;
        if (rx_err !== 1'b0) begin
            errors++; $display("FAIL s2_rx_error: got %b want 0", rx_err);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        pops       = 0;
        rd_empty   = 0;
        rst        = 1'b1;
        en         = '0;
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;

        test_reset();
        test_frame_8n1();
        test_parity();
        test_back_to_back();
        test_enable();
        test_reset_mid_frame();
        test_two_stop();

        checks++;
        if (rd_empty != 0) begin
            errors++; $display("FAIL rd_while_empty: got %0d want 0", rd_empty);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
